// File: rtl/status_register.sv
// ============================================================================
// Module  : status_register
// Purpose : Processor status flags N,V,D,I,Z,C with delayed IRQ mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module status_register #(
    parameter bit CLEAR_D_ON_INTERRUPT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       update_nz,
    input  logic       update_c,
    input  logic       update_v,
    input  logic       bit_test,
    input  logic [2:0] flag_op,
    input  logic       load_from_bus,
    input  logic [7:0] data_in,
    input  logic       interrupt_entry,
    input  logic       brk_flag,
    input  logic       instr_boundary,
    output logic [7:0] status_out,
    output logic       carry_flag,
    output logic       decimal_flag,
    output logic       irq_mask
);

    localparam logic [2:0] c_FLAG_CLC = 3'd1;
    localparam logic [2:0] c_FLAG_SEC = 3'd2;
    localparam logic [2:0] c_FLAG_CLI = 3'd3;
    localparam logic [2:0] c_FLAG_SEI = 3'd4;
    localparam logic [2:0] c_FLAG_CLV = 3'd5;
    localparam logic [2:0] c_FLAG_CLD = 3'd6;
    localparam logic [2:0] c_FLAG_SED = 3'd7;

    logic r_n, r_v, r_d, r_i, r_z, r_c, r_irq_mask;
    logic w_n, w_v, w_d, w_i, w_z, w_c;

    // Later assignments win: ALU < BIT < flag_op < interrupt entry.
    always_comb begin
        w_n = r_n;
        w_v = r_v;
        w_d = r_d;
        w_i = r_i;
        w_z = r_z;
        w_c = r_c;
        if (load_from_bus) begin
            w_n = data_in[7];
            w_v = data_in[6];
            w_d = data_in[3];
            w_i = data_in[2];
            w_z = data_in[1];
            w_c = data_in[0];
        end else begin
            if (update_nz) begin
                w_n = alu_negative;
                w_z = alu_zero;
            end
            if (update_v) begin
                w_v = alu_overflow;
            end
            if (update_c) begin
                w_c = alu_carry;
            end
            if (bit_test) begin
                w_n = data_in[7];
                w_v = data_in[6];
                w_z = alu_zero;
            end
            case (flag_op)
                c_FLAG_CLC: w_c = 1'b0;
                c_FLAG_SEC: w_c = 1'b1;
                c_FLAG_CLI: w_i = 1'b0;
                c_FLAG_SEI: w_i = 1'b1;
                c_FLAG_CLV: w_v = 1'b0;
                c_FLAG_CLD: w_d = 1'b0;
                c_FLAG_SED: w_d = 1'b1;
                default:    w_c = w_c;
            endcase
            if (interrupt_entry) begin
                w_i = 1'b1;
                if (CLEAR_D_ON_INTERRUPT) begin
                    w_d = 1'b0;
                end
            end
        end
    end

    // irq_mask samples the pre-edge I, giving one instruction of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n        <= 1'b0;
            r_v        <= 1'b0;
            r_d        <= 1'b0;
            r_i        <= 1'b1;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_irq_mask <= 1'b1;
        end else if (rdy) begin
            r_n <= w_n;
            r_v <= w_v;
            r_d <= w_d;
            r_i <= w_i;
            r_z <= w_z;
            r_c <= w_c;
            if (instr_boundary) begin
                r_irq_mask <= r_i;
            end
        end
    end

    assign status_out   = {r_n, r_v, 1'b1, brk_flag, r_d, r_i, r_z, r_c};
    assign carry_flag   = r_c;
    assign decimal_flag = r_d;
    assign irq_mask     = r_irq_mask;

endmodule

`default_nettype wire

// File: tb/tb_status_register.sv
// ============================================================================
// Module  : tb_status_register
// Purpose : Self-checking bench for status_register (both parameter values).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_status_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       rdy;
    logic       alu_carry, alu_zero, alu_negative, alu_overflow;
    logic       update_nz, update_c, update_v, bit_test;
    logic [2:0] flag_op;
    logic       load_from_bus;
    logic [7:0] data_in;
    logic       interrupt_entry, brk_flag, instr_boundary;

    logic [7:0] so1, so0;
    logic       cf1, cf0, df1, df0, im1, im0;

    // Reference state: flags packed in status-byte positions (bit 4 unused).
    logic [7:0] m1, m0;
    logic       k1, k0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    status_register #(.CLEAR_D_ON_INTERRUPT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .rdy(rdy),
        .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .update_nz(update_nz), .update_c(update_c), .update_v(update_v),
        .bit_test(bit_test), .flag_op(flag_op), .load_from_bus(load_from_bus),
        .data_in(data_in), .interrupt_entry(interrupt_entry),
        .brk_flag(brk_flag), .instr_boundary(instr_boundary),
        .status_out(so1), .carry_flag(cf1), .decimal_flag(df1), .irq_mask(im1)
    );

    status_register #(.CLEAR_D_ON_INTERRUPT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .rdy(rdy),
        .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .update_nz(update_nz), .update_c(update_c), .update_v(update_v),
        .bit_test(bit_test), .flag_op(flag_op), .load_from_bus(load_from_bus),
        .data_in(data_in), .interrupt_entry(interrupt_entry),
        .brk_flag(brk_flag), .instr_boundary(instr_boundary),
        .status_out(so0), .carry_flag(cf0), .decimal_flag(df0), .irq_mask(im0)
    );

    function automatic logic [7:0] next_flags(input logic [7:0] f, input bit clr_d);
        logic [7:0] r;
        r = f;
        if (update_nz) begin r[7] = alu_negative; r[1] = alu_zero; end
        if (update_v)  r[6] = alu_overflow;
        if (update_c)  r[0] = alu_carry;
        if (bit_test)  begin r[7] = data_in[7]; r[6] = data_in[6]; r[1] = alu_zero; end
        case (flag_op)
            3'd1: r[0] = 1'b0;
            3'd2: r[0] = 1'b1;
            3'd3: r[2] = 1'b0;
            3'd4: r[2] = 1'b1;
            3'd5: r[6] = 1'b0;
            3'd6: r[3] = 1'b0;
            3'd7: r[3] = 1'b1;
            default: ;
        endcase
        if (interrupt_entry) begin
            r[2] = 1'b1;
            if (clr_d) r[3] = 1'b0;
        end
        if (load_from_bus) r = data_in;
        r[5] = 1'b1;
        r[4] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] expect_so(input logic [7:0] f);
        return {f[7:5], brk_flag, f[3:0]};
    endfunction

    task automatic model_reset();
        m1 = 8'h24; m0 = 8'h24; k1 = 1'b1; k0 = 1'b1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; alu_carry = 0; alu_zero = 0; alu_negative = 0; alu_overflow = 0;
        update_nz = 0; update_c = 0; update_v = 0; bit_test = 0; flag_op = 3'd0;
        load_from_bus = 0; data_in = 8'h00; interrupt_entry = 0; brk_flag = 0;
        instr_boundary = 0;
    endtask

    // Advance the model with the current inputs, then cross one active edge.
    task automatic tick();
        logic [7:0] n1, n0;
        if (rdy) begin
            n1 = next_flags(m1, 1'b1);
            n0 = next_flags(m0, 1'b0);
            if (instr_boundary) begin k1 = m1[2]; k0 = m0[2]; end
            m1 = n1;
            m0 = n0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        idle_inputs();
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (so1 !== 8'h24) begin failures++; $display("FAIL reset_init status_out got=%h exp=24", so1); end
        idle_inputs(); flag_op = 3'd2; tick();
        flag_op = 3'd7; tick();
        flag_op = 3'd3; instr_boundary = 1; tick(); tick();
        flag_op = 3'd0; instr_boundary = 0;
        checks++;
        if (so1 !== 8'h29 || im1 !== 1'b0) begin failures++; $display("FAIL reset_pre status_out got=%h exp=29 irq_mask got=%b exp=0", so1, im1); end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (so1 !== 8'h24 || im1 !== 1'b1 || cf1 !== 1'b0 || df1 !== 1'b0) begin
            failures++; $display("FAIL reset_async status_out got=%h exp=24 irq_mask got=%b exp=1", so1, im1);
        end
        brk_flag = 1'b1;
        #1;
        checks++;
        if (so1 !== 8'h34) begin failures++; $display("FAIL reset_brk status_out got=%h exp=34", so1); end
        brk_flag = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_updates();
        do_reset();
        update_nz = 1; update_c = 1; update_v = 1;
        alu_negative = 1; alu_zero = 0; alu_carry = 1; alu_overflow = 1;
        tick();
        checks++;
        if (so1 !== 8'hE5 || cf1 !== 1'b1) begin failures++; $display("FAIL alu_all status_out got=%h exp=e5", so1); end
        idle_inputs(); update_nz = 1; alu_zero = 1; alu_negative = 0;
        tick();
        checks++;
        if (so1 !== 8'h67) begin failures++; $display("FAIL alu_nz status_out got=%h exp=67", so1); end
        idle_inputs();
    endtask

    task automatic test_priority();
        flag_op = 3'd1; tick();
        checks++;
        if (so1 !== 8'h66) begin failures++; $display("FAIL prio_clc status_out got=%h exp=66", so1); end
        flag_op = 3'd2; update_c = 1; alu_carry = 0; tick();
        checks++;
        if (cf1 !== 1'b1 || so1 !== 8'h67) begin failures++; $display("FAIL prio_sec carry got=%b exp=1 status got=%h exp=67", cf1, so1); end
        idle_inputs(); load_from_bus = 1; data_in = 8'hFF; flag_op = 3'd1; tick();
        checks++;
        if (so1 !== 8'hEF || cf1 !== 1'b1) begin failures++; $display("FAIL prio_load status_out got=%h exp=ef", so1); end
        idle_inputs(); load_from_bus = 1; data_in = 8'h30; tick();
        checks++;
        if (so1 !== 8'h20) begin failures++; $display("FAIL load_b5b4 status_out got=%h exp=20", so1); end
        idle_inputs();
    endtask

    task automatic test_bit();
        load_from_bus = 1; data_in = 8'h01; tick();
        idle_inputs(); bit_test = 1; data_in = 8'hC0; alu_zero = 1; update_nz = 1; alu_negative = 0;
        tick();
        checks++;
        if (so1 !== 8'hE3) begin failures++; $display("FAIL bit_test status_out got=%h exp=e3", so1); end
        idle_inputs();
    endtask

    task automatic test_irq_mask();
        do_reset();
        flag_op = 3'd3; instr_boundary = 1; tick();
        checks++;
        if (im1 !== 1'b1 || so1[2] !== 1'b0) begin failures++; $display("FAIL irq_k irq_mask got=%b exp=1 I got=%b exp=0", im1, so1[2]); end
        idle_inputs(); tick();
        checks++;
        if (im1 !== 1'b1) begin failures++; $display("FAIL irq_nobnd irq_mask got=%b exp=1", im1); end
        rdy = 0; instr_boundary = 1; tick();
        checks++;
        if (im1 !== 1'b1) begin failures++; $display("FAIL irq_rdy0 irq_mask got=%b exp=1", im1); end
        rdy = 1; tick();
        checks++;
        if (im1 !== 1'b0) begin failures++; $display("FAIL irq_bnd irq_mask got=%b exp=0", im1); end
        idle_inputs();
    endtask

    task automatic test_interrupt_entry();
        flag_op = 3'd7; tick();
        flag_op = 3'd0; interrupt_entry = 1; update_c = 1; alu_carry = 1; tick();
        checks++;
        if (so1[2] !== 1'b1 || df1 !== 1'b0 || cf1 !== 1'b1) begin
            failures++; $display("FAIL int_p1 I got=%b D got=%b C got=%b exp I=1 D=0 C=1", so1[2], df1, cf1);
        end
        checks++;
        if (so0[2] !== 1'b1 || df0 !== 1'b1) begin failures++; $display("FAIL int_p0 I got=%b D got=%b exp I=1 D=1", so0[2], df0); end
        idle_inputs(); flag_op = 3'd3; interrupt_entry = 1; tick();
        checks++;
        if (so1[2] !== 1'b1) begin failures++; $display("FAIL int_cli I got=%b exp=1", so1[2]); end
        idle_inputs();
    endtask

    task automatic test_php_brk();
        load_from_bus = 1; data_in = 8'h85; tick();
        idle_inputs(); brk_flag = 1; #1;
        checks++;
        if (so1 !== 8'hB5) begin failures++; $display("FAIL php_brk status_out got=%h exp=b5", so1); end
        brk_flag = 0; #1;
        checks++;
        if (so1 !== 8'hA5) begin failures++; $display("FAIL php_nobrk status_out got=%h exp=a5", so1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom % 8) != 0;
            alu_carry = $urandom; alu_zero = $urandom; alu_negative = $urandom; alu_overflow = $urandom;
            update_nz = $urandom; update_c = $urandom; update_v = $urandom;
            bit_test = ($urandom % 6) == 0;
            flag_op = ($urandom % 2) ? 3'($urandom) : 3'd0;
            load_from_bus = ($urandom % 10) == 0;
            data_in = 8'($urandom);
            interrupt_entry = ($urandom % 8) == 0;
            brk_flag = $urandom;
            instr_boundary = $urandom;
            tick();
            checks++;
            if (so1 !== expect_so(m1) || cf1 !== m1[0] || df1 !== m1[3] || im1 !== k1) begin
                failures++; $display("FAIL rand_p1 n=%0d status got=%h exp=%h irq_mask got=%b exp=%b", n, so1, expect_so(m1), im1, k1);
            end
            checks++;
            if (so0 !== expect_so(m0) || cf0 !== m0[0] || df0 !== m0[3] || im0 !== k0) begin
                failures++; $display("FAIL rand_p0 n=%0d status got=%h exp=%h irq_mask got=%b exp=%b", n, so0, expect_so(m0), im0, k0);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_updates();
        test_priority();
        test_bit();
        test_irq_mask();
        test_interrupt_entry();
        test_php_brk();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
